// File: rtl/glitch_pulse_ctrl.sv
// Glitch-enable pulse controller.
//
// After an arm, waits for a rising edge on the asynchronous target trigger.
// It then waits a programmed delay and emits a programmed number of
// enable pulses on `cnt`. Each pulse has a programmed width, and the pulses
// are separated by a programmed gap. `cnt` drives the clock-glitch mux select.
//
// Ports:
//   clk_in1    - system clock (same clock as the glitch mux)
//   reset      - synchronous, active-high reset
//   arm        - strobe: latch cfg_* into shadow registers and arm
//   abort      - strobe: cancel any operation in progress
//   trigger    - asynchronous target trigger, rising edge starts the sequence
//   cfg_delay  - cycles from trigger detect to the first pulse
//   cfg_width  - pulse high time in cycles (must be nonzero)
//   cfg_gap    - low time between pulses (0 treated as 1)
//   cfg_repeat - number of pulses (0 treated as 1)
//   cnt        - registered glitch enable
//   busy       - high while armed or sequencing
//   done       - one-cycle pulse on normal completion
//   cfg_err    - one-cycle pulse when an arm is rejected (width == 0)
module glitch_pulse_ctrl #(
    parameter int unsigned DLY_W = 16,
    parameter int unsigned WID_W = 8,
    parameter int unsigned REP_W = 4
) (
    input  logic             clk_in1,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [WID_W-1:0] cfg_gap,
    input  logic [REP_W-1:0] cfg_repeat,
    output logic             cnt,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    // One shared down-counter times the delay, pulse and gap phases.
    localparam int unsigned TmrW = (DLY_W > WID_W) ? DLY_W : WID_W;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StDelay,
        StPulse,
        StGap,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [DLY_W-1:0] dly_sh_q, dly_sh_d;
    logic [WID_W-1:0] wid_sh_q, wid_sh_d;
    logic [WID_W-1:0] gap_sh_q, gap_sh_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic             cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             trig_edge;

    assign trig_edge = sync2_q & ~prev_q;

    always_comb begin
        state_d  = state_q;
        dly_sh_d = dly_sh_q;
        wid_sh_d = wid_sh_q;
        gap_sh_d = gap_sh_q;
        rep_d    = rep_q;
        tmr_d    = tmr_q;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort beats arm on the same cycle
                if (arm && !abort) begin
                    if (cfg_width != '0) begin
                        dly_sh_d = cfg_delay;
                        wid_sh_d = cfg_width;
                        gap_sh_d = (cfg_gap == '0) ? WID_W'(1) : cfg_gap;
                        rep_d    = (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
                        state_d  = StArmed;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StArmed: begin
                if (trig_edge) begin
                    if (dly_sh_q == '0) begin
                        tmr_d   = TmrW'(wid_sh_q);
                        state_d = StPulse;
                    end else begin
                        tmr_d   = TmrW'(dly_sh_q);
                        state_d = StDelay;
                    end
                end
            end
            StDelay: begin
                if (tmr_q == TmrW'(1)) begin
                    tmr_d   = TmrW'(wid_sh_q);
                    state_d = StPulse;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StPulse: begin
                if (tmr_q == TmrW'(1)) begin
                    if (rep_q == REP_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        rep_d   = rep_q - REP_W'(1);
                        tmr_d   = TmrW'(gap_sh_q);
                        state_d = StGap;
                    end
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StGap: begin
                if (tmr_q == TmrW'(1)) begin
                    tmr_d   = TmrW'(wid_sh_q);
                    state_d = StPulse;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end

        // Outputs are registered copies of the next state so they line up
        // with the state they describe.
        cnt_d  = (state_d == StPulse);
        busy_d = (state_d == StArmed) || (state_d == StDelay) ||
                 (state_d == StPulse) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state_q  <= StIdle;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            dly_sh_q <= '0;
            wid_sh_q <= '0;
            gap_sh_q <= '0;
            rep_q    <= '0;
            tmr_q    <= '0;
            cnt_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= trigger;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            dly_sh_q <= dly_sh_d;
            wid_sh_q <= wid_sh_d;
            gap_sh_q <= gap_sh_d;
            rep_q    <= rep_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cnt     = cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_glitch_pulse_ctrl.sv
// Scoreboard bench for glitch_pulse_ctrl. Stimulus pushes the expected
// output changes (cycle number plus {cnt,busy,done,cfg_err}) into a queue; the
// monitor pops one entry per observed change of the output vector.
module tb_glitch_pulse_ctrl;

    logic        clk_in1 = 1'b0;
    logic        reset   = 1'b1;
    logic        arm     = 1'b0;
    logic        abort   = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] cfg_delay  = '0;
    logic [7:0]  cfg_width  = '0;
    logic [7:0]  cfg_gap    = '0;
    logic [3:0]  cfg_repeat = '0;
    logic        cnt, busy, done, cfg_err;

    glitch_pulse_ctrl #(
        .DLY_W(16),
        .WID_W(8),
        .REP_W(4)
    ) dut (
        .clk_in1   (clk_in1),
        .reset     (reset),
        .arm       (arm),
        .abort     (abort),
        .trigger   (trigger),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .cfg_gap   (cfg_gap),
        .cfg_repeat(cfg_repeat),
        .cnt       (cnt),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk_in1 = ~clk_in1;

    typedef struct {
        int         cyc;
        logic [3:0] vec;  // {cnt, busy, done, cfg_err}
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [3:0] prev_vec = 4'b0000;

    always @(posedge clk_in1) cyc <= cyc + 1;

    // Monitor: sample on the falling edge, compare every change of outputs.
    always @(negedge clk_in1) begin
        logic [3:0] vec;
        exp_t       e;
        vec = {cnt, busy, done, cfg_err};
        if (mon_en && (vec !== prev_vec)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b (no change expected)", cyc, vec);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.vec !== vec)) begin
                    errors++;
                    $display("FAIL out_change got cyc=%0d vec=%b expected cyc=%0d vec=%b",
                             cyc, vec, e.cyc, e.vec);
                end
            end
            prev_vec = vec;
        end
    end

    task automatic push(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in1);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) @(negedge clk_in1);
    endtask

    // Drive one arm strobe; idle says whether the block should accept it.
    task automatic do_arm(input int d, input int w, input int g, input int r, input bit idle);
        int c;
        c          = cyc;
        cfg_delay  = 16'(d);
        cfg_width  = 8'(w);
        cfg_gap    = 8'(g);
        cfg_repeat = 4'(r);
        arm        = 1'b1;
        if (idle) begin
            if (w != 0) begin
                push(c + 1, 4'b0100);
            end else begin
                push(c + 1, 4'b0001);
                push(c + 2, 4'b0000);
            end
        end
        tick(1);
        arm = 1'b0;
    endtask

    task automatic fire(output int t);
        t       = cyc;
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    // Expected pulse train for a trigger driven in cycle t (edge seen at t+2).
    task automatic push_seq(input int t, input int d, input int w, input int g, input int r,
                            output int end_c);
        int s, gg, rr, st;
        s     = t + 3 + d;
        gg    = (g == 0) ? 1 : g;
        rr    = (r == 0) ? 1 : r;
        end_c = s;
        for (int i = 0; i < rr; i++) begin
            st = s + i * (w + gg);
            push(st, 4'b1100);
            if (i < rr - 1) begin
                push(st + w, 4'b0100);
            end else begin
                push(st + w, 4'b0010);
                push(st + w + 1, 4'b0000);
                end_c = st + w;
            end
        end
    endtask

    initial begin
        int t, e, s;

        tick(3);
        checks++;
        if ({cnt, busy, done, cfg_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got=%b expected=0000", {cnt, busy, done, cfg_err});
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // Basic timing
        do_arm(10, 3, 2, 1, 1'b1);
        tick(2);
        fire(t);
        push_seq(t, 10, 3, 2, 1, e);
        run_to(e + 4);

        // Repeat with gap=0 -> 1,1,0,1,1,0,1,1
        do_arm(0, 2, 0, 3, 1'b1);
        tick(2);
        fire(t);
        push_seq(t, 0, 2, 0, 3, e);
        run_to(e + 4);

        // Rejected arm, then trigger gives nothing; trigger in IDLE gives nothing
        do_arm(5, 0, 1, 1, 1'b1);
        tick(2);
        fire(t);
        tick(12);

        // Trigger held high before arm: no edge until it falls and rises
        trigger = 1'b1;
        tick(4);
        do_arm(0, 2, 1, 1, 1'b1);
        tick(6);
        trigger = 1'b0;
        tick(4);
        fire(t);
        push_seq(t, 0, 2, 1, 1, e);
        run_to(e + 4);

        // Abort during the 5th high cycle of a 20-cycle pulse
        do_arm(0, 20, 1, 1, 1'b1);
        tick(2);
        fire(t);
        s = t + 3;
        push(s, 4'b1100);
        push(s + 5, 4'b0000);
        run_to(s + 4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(25);

        // Re-arm after abort
        do_arm(3, 4, 2, 2, 1'b1);
        tick(2);
        fire(t);
        push_seq(t, 3, 4, 2, 2, e);
        run_to(e + 4);

        // Reset during GAP with repeat=4, then trigger without re-arm
        do_arm(0, 2, 3, 4, 1'b1);
        tick(2);
        fire(t);
        s = t + 3;
        push(s, 4'b1100);
        push(s + 2, 4'b0100);
        push(s + 4, 4'b0000);
        run_to(s + 3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        fire(t);
        tick(15);

        // Arm while busy is ignored (width stays 3), arm in DONE is ignored
        do_arm(2, 3, 1, 1, 1'b1);
        do_arm(0, 7, 1, 1, 1'b0);
        tick(1);
        fire(t);
        push_seq(t, 2, 3, 1, 1, e);
        run_to(e);
        do_arm(0, 5, 1, 1, 1'b0);
        tick(3);
        fire(t);
        tick(15);

        // abort + arm in the same IDLE cycle: stays IDLE
        abort = 1'b1;
        do_arm(0, 3, 1, 1, 1'b0);
        abort = 1'b0;
        tick(2);
        fire(t);
        tick(15);

        // Maximum delay and width
        do_arm(65535, 255, 0, 1, 1'b1);
        tick(2);
        fire(t);
        push_seq(t, 65535, 255, 0, 1, e);
        run_to(e + 4);

        tick(5);
        while (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_change expected cyc=%0d vec=%b got no change", x.cyc, x.vec);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
